pipe_ctrl: RTL

//  Control unit for the 4-stage (fetch/decode/execute/access) 16-bit CPU datapath.

---
 rtl/pipe_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 4-stage 16-bit CPU: decodes EX/AC IRs, resolves redirects,
// stalls on the data-memory handshake, latches HALT and counts wait cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// BOOT    | first cycle after reset, loads PC from fetch address 0
// RUN     | normal issue, all pipe registers advance
// MEMWAIT | ld/st in EX waiting on i_ldst_ready, pipe frozen
// HALT    | halt executed, everything idle until reset
module pipe_ctrl #(
  parameter logic [15:0] NOP_IR = 16'h0000,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      r_ir_dc,
  input  logic [15:0]      r_ir_ex,
  input  logic [15:0]      r_ir_ac,
  input  logic             r_alu_n,
  input  logic             r_alu_z,
  input  logic             i_ldst_ready,
  output logic             ld_pc,
  output logic [1:0]       pc_in_sel,
  output logic [1:0]       pc_addr_sel,
  output logic             ld_pc_dc,
  output logic             ld_ir_dc,
  output logic             ld_rx,
  output logic             ld_ry,
  output logic             ld_pc_ex,
  output logic             ld_ir_ex,
  output logic             ld_pc_ac,
  output logic             ld_ir_ac,
  output logic [1:0]       sel_alu_a,
  output logic [1:0]       sel_alu_b,
  output logic             addsub,
  output logic             ld_alu_r,
  output logic             ld_nz,
  output logic             r_jump,
  output logic             s_jump,
  output logic             wr_en,
  output logic [2:0]       sel_datain,
  output logic             o_ldst_rd,
  output logic             o_ldst_wr,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVHI = 4'd6;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JN   = 4'd10;
  localparam logic [3:0] OP_CALL = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             ld_pipe;
  logic             stall_inc;
  logic [CNT_W-1:0] stall_cnt;

  // The dc IR is carried for completeness; all decisions are made in EX and AC.
  logic [15:0] ir_dc_unused;
  assign ir_dc_unused = r_ir_dc;

  // A bubble must never decode as opcode 0 (mv), so empty stages are mapped to nop.
  logic       ex_vld, ac_vld;
  logic [3:0] ex_op, ac_op;
  logic       ex_imm;

  assign ex_vld = (r_ir_ex != NOP_IR);
  assign ac_vld = (r_ir_ac != NOP_IR);
  assign ex_op  = r_ir_ex[3:0];
  assign ac_op  = r_ir_ac[3:0];
  assign ex_imm = r_ir_ex[4];

  logic ex_mv, ex_add, ex_sub, ex_cmp, ex_ld, ex_st, ex_mvhi;
  logic ex_j, ex_jz, ex_jn, ex_call, ex_halt;
  logic ex_mem, ex_taken;

  assign ex_mv    = ex_vld && (ex_op == OP_MV);
  assign ex_add   = ex_vld && (ex_op == OP_ADD);
  assign ex_sub   = ex_vld && (ex_op == OP_SUB);
  assign ex_cmp   = ex_vld && (ex_op == OP_CMP);
  assign ex_ld    = ex_vld && (ex_op == OP_LD);
  assign ex_st    = ex_vld && (ex_op == OP_ST);
  assign ex_mvhi  = ex_vld && (ex_op == OP_MVHI);
  assign ex_j     = ex_vld && (ex_op == OP_J);
  assign ex_jz    = ex_vld && (ex_op == OP_JZ);
  assign ex_jn    = ex_vld && (ex_op == OP_JN);
  assign ex_call  = ex_vld && (ex_op == OP_CALL);
  assign ex_halt  = ex_vld && (ex_op == OP_HALT);
  assign ex_mem   = ex_ld || ex_st;
  assign ex_taken = ex_j || ex_call || (ex_jz && r_alu_z) || (ex_jn && r_alu_n);

  logic       ac_wr;
  logic [2:0] ac_sel;

  always_comb begin
    ac_wr  = 1'b0;
    ac_sel = 3'd0;
    if (ac_vld) begin
      case (ac_op)
        OP_MV, OP_ADD, OP_SUB, OP_MVHI: begin ac_wr = 1'b1; ac_sel = 3'd1; end
        OP_LD:                          begin ac_wr = 1'b1; ac_sel = 3'd2; end
        OP_CALL:                        begin ac_wr = 1'b1; ac_sel = 3'd3; end
        default:                        begin ac_wr = 1'b0; ac_sel = 3'd0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_BOOT;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    stall_inc   = 1'b0;
    ld_pipe     = 1'b0;
    ld_pc       = 1'b0;
    pc_in_sel   = 2'd0;
    pc_addr_sel = 2'd0;
    sel_alu_a   = 2'd0;
    sel_alu_b   = 2'd0;
    addsub      = 1'b0;
    ld_alu_r    = 1'b0;
    ld_nz       = 1'b0;
    r_jump      = 1'b0;
    s_jump      = 1'b0;
    wr_en       = 1'b0;
    sel_datain  = 3'd0;
    o_ldst_rd   = 1'b0;
    o_ldst_wr   = 1'b0;
    o_halted    = 1'b0;

    case (state)
      S_BOOT: begin
        ld_pc     = 1'b1;
        state_nxt = S_RUN;
      end

      S_RUN, S_MEMWAIT: begin
        if (ex_mv) begin
          sel_alu_a = 2'd1;
          sel_alu_b = ex_imm ? 2'd1 : 2'd0;
        end
        if (ex_add || ex_sub || ex_cmp) begin
          sel_alu_b = ex_imm ? 2'd1 : 2'd0;
          addsub    = ex_sub || ex_cmp;
        end
        if (ex_mvhi) begin
          sel_alu_b = 2'd2;
        end
        o_ldst_rd = ex_ld;
        o_ldst_wr = ex_st;

        if (state == S_RUN) begin
          ld_alu_r   = ex_mv || ex_add || ex_sub || ex_mvhi;
          ld_nz      = ex_cmp;
          wr_en      = ac_wr;
          sel_datain = ac_sel;
          if (ex_taken) begin
            pc_addr_sel = ex_imm ? 2'd1 : 2'd2;
            pc_in_sel   = ex_imm ? 2'd1 : 2'd2;
            r_jump      = ex_imm;
            s_jump      = !ex_imm;
          end
          if (ex_halt) begin
            ld_pipe   = 1'b1;
            state_nxt = S_HALT;
          end else if (ex_mem && !i_ldst_ready) begin
            stall_inc = 1'b1;
            state_nxt = S_MEMWAIT;
          end else begin
            ld_pipe = 1'b1;
          end
        end else if (i_ldst_ready) begin
          // The AC instruction already wrote back on the entry cycle; do not repeat it.
          ld_alu_r   = ex_mv || ex_add || ex_sub || ex_mvhi;
          ld_nz      = ex_cmp;
          sel_datain = ac_sel;
          ld_pipe    = 1'b1;
          state_nxt  = S_RUN;
        end else begin
          stall_inc = 1'b1;
        end
        if (ld_pipe) begin
          ld_pc = 1'b1;
        end
      end

      S_HALT: begin
        o_halted = 1'b1;
      end

      default: begin
        state_nxt = S_BOOT;
      end
    endcase

    // Outputs are forced idle for as long as reset is held, even though BOOT is a Mealy-free state.
    if (!reset) begin
      stall_inc   = 1'b0;
      ld_pipe     = 1'b0;
      ld_pc       = 1'b0;
      pc_in_sel   = 2'd0;
      pc_addr_sel = 2'd0;
      sel_alu_a   = 2'd0;
      sel_alu_b   = 2'd0;
      addsub      = 1'b0;
      ld_alu_r    = 1'b0;
      ld_nz       = 1'b0;
      r_jump      = 1'b0;
      s_jump      = 1'b0;
      wr_en       = 1'b0;
      sel_datain  = 3'd0;
      o_ldst_rd   = 1'b0;
      o_ldst_wr   = 1'b0;
      o_halted    = 1'b0;
    end
  end

  assign ld_pc_dc    = ld_pipe;
  assign ld_ir_dc    = ld_pipe;
  assign ld_rx       = ld_pipe;
  assign ld_ry       = ld_pipe;
  assign ld_pc_ex    = ld_pipe;
  assign ld_ir_ex    = ld_pipe;
  assign ld_pc_ac    = ld_pipe;
  assign ld_ir_ac    = ld_pipe;
  assign o_stall_cnt = stall_cnt;

endmodule
